// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: opcodes, command/response
// records and the control FSM states.
package alu_seq_pkg;

  // Tag width carried inside the command/response records. The top-level
  // TAG_W parameter must match this value.
  localparam int SEQ_TAG_W = 3;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NOTA = 2'b10,
    OP_ORB  = 2'b11
  } opcode_e;

  typedef struct packed {
    opcode_e                opcode;
    logic [3:0]             a;
    logic [3:0]             b;
    logic [SEQ_TAG_W-1:0]   tag;
  } cmd_t;

  typedef struct packed {
    logic [4:0]             c;
    opcode_e                opcode;
    logic [SEQ_TAG_W-1:0]   tag;
  } rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_FLUSH  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is taken only
// when a pop happens on the same edge. clear empties the FIFO and drops any
// same-edge push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage array; stale contents are harmless because the pointers reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-issue stage for the clocked 4-bit ALU. Buffers commands, drives
// the ALU inputs, follows each issued command through the ALU latency with a
// token pipeline and captures the result with its tag into a result FIFO.
// Issue is gated by a credit check so a captured result always has room.
//
// Both cmd_* and rsp_* use valid/ready: a transfer happens on a rising edge
// where valid and ready are both high; the sender holds valid and payload
// stable until that edge; ready never depends on valid in the same cycle.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = SEQ_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_opcode,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [1:0]       alu_opcode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  input  logic [4:0]       alu_c,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [4:0]       rsp_c,
  output logic [1:0]       rsp_opcode,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output seq_state_e       dbg_state
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NSTG  = ALU_LAT + 1;

  cmd_t             cmd_in;
  cmd_t             cmd_head;
  rsp_t             res_in;
  rsp_t             res_head;
  logic             cmd_full;
  logic             cmd_empty;
  logic             res_full;
  logic             res_empty;
  logic [CNT_W-1:0] cmd_count;
  logic [CNT_W-1:0] res_count;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] cmd_count_nxt;
  logic [CNT_W-1:0] res_count_nxt;
  logic [CNT_W-1:0] inflight_nxt;
  logic             accept;
  logic             issue;
  logic             capture;
  logic             rsp_pop;
  logic             credit_ok;
  logic             work_nxt;
  logic             pipe_vld [NSTG];
  opcode_e          pipe_op  [NSTG];
  logic [TAG_W-1:0] pipe_tag [NSTG];
  seq_state_e       state;

  assign cmd_in = '{opcode: opcode_e'(cmd_opcode), a: cmd_a, b: cmd_b, tag: cmd_tag};

  // A full command FIFO holds ready low even on a popping cycle.
  assign cmd_ready = !reset && !cmd_full;
  assign accept    = cmd_valid && cmd_ready;

  // Every in-flight token plus every buffered result owns one result slot.
  assign credit_ok = !res_full &&
                     (({1'b0, inflight} + {1'b0, res_count}) < (CNT_W+1)'(DEPTH));
  assign issue     = !cmd_empty && credit_ok && !flush && (state != ST_FLUSH);

  assign capture   = pipe_vld[NSTG-1];
  assign res_in    = '{c: alu_c, opcode: pipe_op[NSTG-1], tag: pipe_tag[NSTG-1]};

  assign rsp_valid  = !res_empty;
  assign rsp_pop    = rsp_valid && rsp_ready;
  assign rsp_c      = res_empty ? 5'd0  : res_head.c;
  assign rsp_opcode = res_empty ? 2'b00 : res_head.opcode;
  assign rsp_tag    = res_empty ? '0    : res_head.tag;

  // Occupancy after the coming edge, used for the registered busy flag.
  assign cmd_count_nxt = flush ? '0 : (cmd_count + CNT_W'(accept) - CNT_W'(issue));
  assign res_count_nxt = res_count + CNT_W'(capture) - CNT_W'(rsp_pop);
  assign inflight_nxt  = inflight + CNT_W'(issue) - CNT_W'(capture);
  assign work_nxt      = (cmd_count_nxt != '0) || (res_count_nxt != '0) ||
                         (inflight_nxt != '0);

  sync_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .push    (accept),
    .pop     (issue),
    .wr_data (cmd_in),
    .rd_data (cmd_head),
    .full    (cmd_full),
    .empty   (cmd_empty),
    .count   (cmd_count)
  );

  sync_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (1'b0),
    .push    (capture),
    .pop     (rsp_pop),
    .wr_data (res_in),
    .rd_data (res_head),
    .full    (res_full),
    .empty   (res_empty),
    .count   (res_count)
  );

  // ALU input drive: the FIFO head on an issue edge, zeros otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_opcode <= 2'b00;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
    end else if (issue) begin
      alu_opcode <= cmd_head.opcode;
      alu_a      <= cmd_head.a;
      alu_b      <= cmd_head.b;
    end else begin
      alu_opcode <= 2'b00;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
    end
  end

  // Token pipeline that lines each issued command up with its ALU result.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSTG; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_op[i]  <= OP_ADD;
        pipe_tag[i] <= '0;
      end
      inflight <= '0;
    end else begin
      pipe_vld[0] <= issue;
      pipe_op[0]  <= cmd_head.opcode;
      pipe_tag[0] <= cmd_head.tag;
      for (int i = 1; i < NSTG; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_op[i]  <= pipe_op[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      inflight <= inflight_nxt;
    end
  end

  // Control FSM: tracks idle/active work and holds off issue during a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      busy <= work_nxt;
      case (state)
        ST_IDLE: begin
          if (flush)         state <= ST_FLUSH;
          else if (work_nxt) state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (flush)          state <= ST_FLUSH;
          else if (!work_nxt) state <= ST_IDLE;
        end
        ST_FLUSH: begin
          if (!flush && (inflight == '0)) begin
            state <= work_nxt ? ST_ACTIVE : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a one-stage behavioural ALU attached.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int TAG_W = 3;
  localparam int RW    = 5 + 2 + TAG_W;

  logic             clk_tb;
  logic             reset;
  logic             flush;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_opcode;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic [1:0]       alu_opcode;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [4:0]       alu_c;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [4:0]       rsp_c;
  logic [1:0]       rsp_opcode;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  seq_state_e       dbg_state;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int rsp_cnt = 0;
  logic [RW-1:0] exp_q[$];
  int            rsp_cyc_q[$];
  logic [RW-1:0] mon_exp;

  alu_cmd_sequencer #(.DEPTH(4), .ALU_LAT(1), .TAG_W(TAG_W)) dut (
    .clk        (clk_tb),
    .reset      (reset),
    .flush      (flush),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_c      (rsp_c),
    .rsp_opcode (rsp_opcode),
    .rsp_tag    (rsp_tag),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle counter.
  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  always @(posedge clk_tb) cyc <= cyc + 1;

  // Behavioural ALU_4_bit: one register stage, 5-bit signed result.
  always @(posedge clk_tb) begin
    if (reset) alu_c <= 5'd0;
    else begin
      case (alu_opcode)
        2'b00:   alu_c <= {alu_a[3], alu_a} + {alu_b[3], alu_b};
        2'b01:   alu_c <= {alu_a[3], alu_a} - {alu_b[3], alu_b};
        2'b10:   alu_c <= ~{alu_a[3], alu_a};
        default: alu_c <= {4'd0, |alu_b};
      endcase
    end
  end

  // Reference result from plain integer arithmetic.
  function automatic logic [4:0] ref_c(input logic [1:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = -sa - 1;
      default: r = (b != 4'd0) ? 1 : 0;
    endcase
    return r[4:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every handshaken response must match the queue head.
  always @(negedge clk_tb) begin
    if (!reset && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      rsp_cyc_q.push_back(cyc);
      check("rsp_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("rsp_data", 32'({rsp_c, rsp_opcode, rsp_tag}), 32'(mon_exp));
      end
    end
  end

  // Driver: present one command, wait (bounded) for the handshake.
  task automatic send_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [TAG_W-1:0] tag, input logic [4:0] exp_c,
                          input bit want);
    bit ok;
    ok = 1'b0;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_tag    = tag;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_tb);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("cmd_ready_timeout", 32'(0), 32'(1));
    @(posedge clk_tb); #1;
    cmd_valid = 1'b0;
    if (ok && want) exp_q.push_back({exp_c, op, tag});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_tb);
    #1;
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk_tb);
    @(posedge clk_tb); #1;
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, acc, base;
    bit done;
    logic [1:0] rop;
    logic [3:0] ra, rb;
    logic [TAG_W-1:0] rt;

    reset = 1'b1; flush = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_opcode = 2'b00; cmd_a = 4'd0; cmd_b = 4'd0; cmd_tag = '0;

    // Reset values.
    repeat (3) @(posedge clk_tb);
    @(negedge clk_tb);
    check("reset_cmd_ready", 32'(cmd_ready), 32'(0));
    check("reset_alu", 32'({alu_opcode, alu_a, alu_b}), 32'(0));
    check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    check("reset_rsp", 32'({rsp_c, rsp_opcode, rsp_tag}), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk_tb); #1;
    reset = 1'b0;
    @(negedge clk_tb);
    check("ready_after_reset", 32'(cmd_ready), 32'(1));
    @(posedge clk_tb); #1;

    // Single add, latency and ALU drive timing.
    send_cmd(2'b00, 4'd3, 4'd4, 3'd5, 5'b00111, 1'b1);
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk_tb); #1;
      if (n == 1) check("issue_drive", 32'({alu_opcode, alu_a, alu_b}), 32'({2'b00, 4'd3, 4'd4}));
      if (n == 2) check("issue_clear", 32'({alu_opcode, alu_a, alu_b}), 32'(0));
      if (rsp_valid && lat == 0) lat = n;
    end
    check("latency", 32'(lat), 32'(3));
    wait_drain("drain_single");

    // Back-to-back directed vectors.
    rsp_cyc_q.delete();
    send_cmd(2'b00, 4'b0111, 4'b0111, 3'd1, 5'b01110, 1'b1);
    send_cmd(2'b01, 4'b1000, 4'b0111, 3'd2, 5'b10001, 1'b1);
    send_cmd(2'b11, 4'b0101, 4'b0000, 3'd3, 5'b00000, 1'b1);
    send_cmd(2'b11, 4'b0000, 4'b1000, 3'd4, 5'b00001, 1'b1);
    wait_drain("drain_b2b");
    check("b2b_count", 32'(rsp_cyc_q.size()), 32'(4));
    for (int i = 1; i < rsp_cyc_q.size(); i++)
      check("b2b_gap", 32'(rsp_cyc_q[i] - rsp_cyc_q[i-1]), 32'(1));

    // Backpressure: hold valid until ready stays low.
    rsp_ready = 1'b0;
    acc = 0;
    cmd_valid = 1'b1;
    cmd_opcode = 2'($urandom_range(0, 3)); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
    cmd_tag = 3'($urandom);
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_tb);
      if (cmd_ready) begin
        exp_q.push_back({ref_c(cmd_opcode, cmd_a, cmd_b), cmd_opcode, cmd_tag});
        acc++;
        @(posedge clk_tb); #1;
        cmd_opcode = 2'($urandom_range(0, 3)); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        cmd_tag = 3'($urandom);
      end else begin
        @(posedge clk_tb); #1;
      end
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'(8));
    @(negedge clk_tb);
    check("bp_ready_low", 32'(cmd_ready), 32'(0));
    check("bp_busy", 32'(busy), 32'(1));
    @(posedge clk_tb); #1;
    rsp_ready = 1'b1;
    wait_drain("drain_bp");
    idle(3);
    check("bp_idle_busy", 32'(busy), 32'(0));

    // Flush with results buffered and commands queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3)); ra = 4'($urandom); rb = 4'($urandom); rt = 3'(i);
      send_cmd(rop, ra, rb, rt, ref_c(rop, ra, rb), i < 4);
    end
    idle(6);
    @(negedge clk_tb);
    check("fl_rsp_buffered", 32'(rsp_valid), 32'(1));
    check("fl_cmd_full", 32'(cmd_ready), 32'(0));
    @(posedge clk_tb); #1;
    flush = 1'b1; cmd_valid = 1'b1; cmd_opcode = 2'b00; cmd_a = 4'd1; cmd_b = 4'd1; cmd_tag = 3'd7;
    @(posedge clk_tb); #1;
    flush = 1'b0; cmd_valid = 1'b0;
    idle(3);
    flush = 1'b1; cmd_valid = 1'b1; cmd_opcode = 2'b01; cmd_a = 4'd2; cmd_b = 4'd1; cmd_tag = 3'd6;
    @(negedge clk_tb);
    check("fl_edge_ready", 32'(cmd_ready), 32'(1));
    @(posedge clk_tb); #1;
    flush = 1'b0; cmd_valid = 1'b0;
    idle(5);
    check("fl_busy_held", 32'(busy), 32'(1));
    base = rsp_cnt;
    rsp_ready = 1'b1;
    wait_drain("drain_flush");
    idle(10);
    check("fl_rsp_count", 32'(rsp_cnt - base), 32'(4));
    check("fl_busy_clear", 32'(busy), 32'(0));

    // Reset with two commands in flight.
    send_cmd(2'b00, 4'd1, 4'd2, 3'd1, 5'd3, 1'b0);
    send_cmd(2'b01, 4'd5, 4'd2, 3'd2, 5'd3, 1'b0);
    @(posedge clk_tb); #1;
    reset = 1'b1;
    @(posedge clk_tb);
    @(negedge clk_tb);
    check("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    check("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp", 32'({rsp_c, rsp_opcode, rsp_tag}), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    @(posedge clk_tb); #1;
    reset = 1'b0;
    base = rsp_cnt;
    idle(15);
    check("rst_no_stale", 32'(rsp_cnt - base), 32'(0));

    // Random stream with random response backpressure.
    base = rsp_cnt;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          idle($urandom_range(0, 2));
          rop = 2'($urandom_range(0, 3)); ra = 4'($urandom); rb = 4'($urandom);
          rt = 3'($urandom);
          send_cmd(rop, ra, rb, rt, ref_c(rop, ra, rb), 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk_tb); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    wait_drain("drain_random");
    idle(4);
    check("rnd_rsp_count", 32'(rsp_cnt - base), 32'(50));
    check("rnd_busy_clear", 32'(busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Upstream command-issue stage for the clocked 4-bit ALU (`ALU_4_bit`). It accepts opcode/operand commands over a valid/ready interface, buffers them, drives the ALU's `Opcode`/`A`/`B` inputs, and tracks each issued command through the ALU's register latency. It then captures `C` with the command's tag into a result buffer, which downstream logic drains over a second valid/ready interface. A credit scheme guarantees that no captured result is ever dropped.

## Interface
- `DEPTH`, 4, entries in each of the command FIFO and the result FIFO (power of two, ≥2)
- `ALU_LAT`, 1, ALU register stages between its inputs and `C`
- `TAG_W`, 3, width of the user tag carried with each command
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high. Also drives the ALU's `reset` port.
- `flush` in 1: one-cycle pulse; discards queued, unissued commands.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_opcode` in 2: 00 add, 01 sub, 10 invert A, 11 reduction-OR B.
- `cmd_a`, `cmd_b` in 4: signed operands.
- `cmd_tag` in `TAG_W`
- `alu_opcode` out 2, `alu_a` out 4, `alu_b` out 4: registered drives to the ALU.
- `alu_c` in 5: signed ALU result.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_c` out 5, `rsp_opcode` out 2, `rsp_tag` out `TAG_W`
- `busy` out 1: high if any command is queued, in flight, or buffered.

## Operation
- A command is accepted on an edge where `cmd_valid && cmd_ready`.
  - `cmd_ready` = !reset && command FIFO not full.
  - There is no same-cycle pass-through: a full FIFO holds `cmd_ready` low even if it is popping that cycle.
- Issue happens at an edge when all three hold:
  - the command FIFO is non-empty,
  - `inflight + result_count < DEPTH` (credit check),
  - `flush` is low.
- On issue:
  - `alu_*` load the FIFO head.
  - A token {tag, opcode} enters a shift pipeline `ALU_LAT+1` stages long.
- On a non-issue edge, `alu_*` load 00/0/0.
- When a token exits the pipeline, `alu_c` is written with the token into the result FIFO. The credit check guarantees the result FIFO has room.
- `rsp_*` present the result FIFO head.
  - The head pops on `rsp_valid && rsp_ready`.
  - A push and a pop on the same edge are legal, including when the FIFO is full.
- Control FSM, which only drives `busy` and flush sequencing:
  - IDLE: nothing queued, in flight, or buffered.
  - ACTIVE: any work present.
  - FLUSH: entered on `flush`. The command FIFO is cleared at that edge. Stays in FLUSH until the pipeline is empty, then goes to ACTIVE or IDLE.
  - No issue occurs in FLUSH. Accepts are permitted.
- `flush` edge cases:
  - A command accepted on the same edge as `flush` is dropped.
  - In-flight tokens and buffered results are kept.
- Result width: `rsp_c` is `alu_c` passed through unchanged (5-bit signed). The block does no arithmetic.

## Timing
- Reset values: `cmd_ready`=0, `alu_opcode`=00, `alu_a`=`alu_b`=0, `rsp_valid`=0, `rsp_c`=0, `rsp_opcode`=00, `rsp_tag`=0, `busy`=0. State is IDLE and all FIFOs and pipelines are empty.
- `cmd_ready` rises in the first cycle after `reset` deasserts.
- Minimum latency, into idle, with `ALU_LAT`=1:
  - accept at edge k,
  - issue (`alu_*` valid) after edge k+1,
  - ALU samples at edge k+2,
  - capture at edge k+3,
  - `rsp_valid` high after edge k+3.
- Throughput: one issue per cycle while credits allow.
- With `rsp_ready` stuck low: exactly `DEPTH` commands issue, then `DEPTH` more queue, then `cmd_ready` falls.
- Reset mid-operation clears everything at that edge. In-flight results are discarded, never captured.

## Structure
- Package `alu_seq_pkg`:
  - `opcode_e` enum: `OP_ADD`, `OP_SUB`, `OP_NOTA`, `OP_ORB`.
  - `cmd_t` struct: opcode, a, b, tag.
  - `rsp_t` struct: c, opcode, tag.
  - FSM state enum.
- Sub-module `sync_fifo` (parameterised width/depth, with full, empty and count). It is instantiated twice: once for commands and once for results.
- Credit counter, token pipeline and FSM live in the top.

## Test plan
- Add: A=3, B=4, tag 5 -> one response with `rsp_c`=7, `rsp_opcode`=00, `rsp_tag`=5, and `rsp_valid` high exactly 3 cycles after accept.
- Back-to-back, with `rsp_ready` high:
  - Commands, in order: add 7+7, sub −8−7, reduction-OR B=0, reduction-OR B=1000.
  - Required responses, in order: 01110, 10001, 00000, 00001.
  - Tags are preserved and one response arrives per cycle.
- Backpressure, with `rsp_ready`=0: stream commands until `cmd_ready` falls; exactly 8 are accepted. Then raise `rsp_ready`; all 8 drain in order with no loss.
- Flush:
  - Setup: queue 4 commands while `rsp_ready`=0 and 4 results are already buffered.
  - Pulse `flush` together with a new `cmd_valid`.
  - Result: the buffered results are still delivered, the queued commands and the same-edge command never appear, and `busy` returns to 0.
- Reset mid-stream: assert `reset` while 2 commands are in flight. Next cycle: all outputs are at reset values, and no stale responses appear after release.
- Random: 50 commands with random `rsp_ready`. Every `rsp_c` matches the reference model and ordering is preserved.
